turn_signal_sequencer: RTL

//  Parametrised rear-lamp sequencer. Extends the fixed 3+3 lamp turn/hazard FSM with:
//   - a configurable lamp count per side;
//   - a step-rate prescaler;
//   - a full-on hold phase;
//   - a brake overlay.

---
 rtl/turn_signal_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/turn_signal_sequencer.sv
// ============================================================================
//  Module      : turn_signal_sequencer
//  Description : Parametrised rear-lamp turn/hazard sequencer with step
//                prescaler, full-on hold phase and brake overlay.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module turn_signal_sequencer #(
  parameter int LAMPS      = 3,
  parameter int TICK_DIV   = 1,
  parameter int HOLD_STEPS = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             L,
  input  logic             R,
  input  logic             H,
  input  logic             B,
  output logic [LAMPS-1:0] LightsL,
  output logic [LAMPS-1:0] LightsR,
  output logic             Busy
);

  localparam int SW = $clog2(LAMPS + HOLD_STEPS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [SW-1:0]    c_last_step = SW'(LAMPS + HOLD_STEPS);
  localparam logic [SW-1:0]    c_hold_last = SW'(HOLD_STEPS);
  localparam logic [CW-1:0]    c_cnt_last  = CW'(TICK_DIV - 1);
  localparam logic [LAMPS-1:0] c_all_on    = {LAMPS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_HAZ   = 3'd3,
    S_OFF   = 3'd4
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_step;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_n;
  logic [SW-1:0]   w_step_n;
  logic [CW-1:0]   w_cnt_n;
  logic            w_tick;
  logic [LAMPS-1:0] w_pat;
  logic [LAMPS-1:0] w_brake;
  logic [LAMPS-1:0] w_lights_l_n;
  logic [LAMPS-1:0] w_lights_r_n;

  assign w_tick  = (r_cnt == c_cnt_last);
  assign w_cnt_n = ((r_state == S_IDLE) || w_tick) ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_state_n = r_state;
    w_step_n  = r_step;
    case (r_state)
      S_LEFT, S_RIGHT: begin
        if (w_tick) begin
          if (H) begin
            w_state_n = S_HAZ;
            w_step_n  = '0;
          end else if (r_step < c_last_step) begin
            w_step_n  = r_step + 1'b1;
          end else begin
            w_state_n = S_OFF;
            w_step_n  = '0;
          end
        end
      end
      S_HAZ: begin
        if (w_tick) begin
          if (r_step < c_hold_last) begin
            w_step_n  = r_step + 1'b1;
          end else begin
            w_state_n = S_OFF;
            w_step_n  = '0;
          end
        end
      end
      default: begin
        // IDLE evaluates every cycle; OFF only on its tick, then restarts or idles
        if ((r_state == S_IDLE) || w_tick) begin
          w_step_n = '0;
          if (H || (L && R)) begin
            w_state_n = S_HAZ;
          end else if (L) begin
            w_state_n = S_LEFT;
            w_step_n  = SW'(1);
          end else if (R) begin
            w_state_n = S_RIGHT;
            w_step_n  = SW'(1);
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < LAMPS; gi++) begin : g_pat
    assign w_pat[gi] = (w_step_n > SW'(gi));
  end

  assign w_brake = B ? c_all_on : '0;

  always_comb begin
    w_lights_l_n = w_brake;
    w_lights_r_n = w_brake;
    case (w_state_n)
      S_LEFT:  w_lights_l_n = w_pat;
      S_RIGHT: w_lights_r_n = w_pat;
      S_HAZ: begin
        w_lights_l_n = c_all_on;
        w_lights_r_n = c_all_on;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      LightsL <= '0;
      LightsR <= '0;
      Busy    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_step  <= w_step_n;
      r_cnt   <= w_cnt_n;
      LightsL <= w_lights_l_n;
      LightsR <= w_lights_r_n;
      Busy    <= (w_state_n != S_IDLE);
    end
  end

endmodule

`default_nettype wire
